// File: rtl/fpnew_opgrp_out_arb_if.sv
// ---------------------------------------------------------------------------
// FpnewOpgrpOutArbIf
// Bundles the handshake and data signals between the operation-group result
// ports, the output arbiter and the core-side consumer.
//   in_valid_i  : per-port result valid from the operation groups
//   in_ready_o  : per-port accept from the arbiter (one-hot or zero)
//   in_data_i   : per-port packed result/status/tag word
//   out_valid_o : registered result valid toward the core
//   out_ready_i : core accepts the result
//   out_data_o  : registered winning data word
//   out_idx_o   : port index that produced out_data_o
//   busy_o      : a result is pending in the arbiter or at its inputs
// Modport slave is taken by the arbiter, master by whoever drives it.
// ---------------------------------------------------------------------------
interface fpnew_opgrp_out_arb_if #(
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned DATA_W = 70,
    parameter int unsigned IDX_W  = $clog2(NUM_IN)
);
    logic [NUM_IN-1:0]             in_valid_i;
    logic [NUM_IN-1:0]             in_ready_o;
    logic [NUM_IN-1:0][DATA_W-1:0] in_data_i;
    logic                          out_valid_o;
    logic                          out_ready_i;
    logic [DATA_W-1:0]             out_data_o;
    logic [IDX_W-1:0]              out_idx_o;
    logic                          busy_o;

    modport slave (
        input  in_valid_i,
        input  in_data_i,
        input  out_ready_i,
        output in_ready_o,
        output out_valid_o,
        output out_data_o,
        output out_idx_o,
        output busy_o
    );

    modport master (
        output in_valid_i,
        output in_data_i,
        output out_ready_i,
        input  in_ready_o,
        input  out_valid_o,
        input  out_data_o,
        input  out_idx_o,
        input  busy_o
    );
endinterface

// File: rtl/fpnew_opgrp_out_arb.sv
// ---------------------------------------------------------------------------
// FpnewOpgrpOutArb
// Round-robin arbiter collecting results from NUM_IN operation groups into a
// single registered output stage toward the core.
//   clk_i   : sole clock, rising edge
//   rst_i   : asynchronous active-high reset
//   flush_i : synchronous flush, drops the buffered result and restarts the
//             round-robin scan at port 0
//   bus     : slave modport carrying the per-port inputs and the output
// ---------------------------------------------------------------------------
module fpnew_opgrp_out_arb #(
    parameter int unsigned NUM_IN = 5,
    parameter int unsigned DATA_W = 70,
    parameter int unsigned IDX_W  = $clog2(NUM_IN)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  flush_i,
    fpnew_opgrp_out_arb_if.slave  bus
);

    logic                 r_valid;
    logic [DATA_W-1:0]    r_data;
    logic [IDX_W-1:0]     r_idx;
    logic [IDX_W-1:0]     r_ptr;

    logic                 w_ld;
    logic                 w_found;
    logic [IDX_W-1:0]     w_winner;
    logic [IDX_W-1:0]     w_nextPtr;
    logic [IDX_W:0]       w_cand;
    logic [NUM_IN-1:0]    w_grant;

    // The output register may take a new word when it is empty or being
    // drained this cycle; a flush blocks loading outright.
    assign w_ld = !flush_i && (!r_valid || bus.out_ready_i);

    // Scan the ports starting at the round-robin pointer. The candidate index
    // carries one extra bit so the sum never overflows, and is folded back
    // explicitly so a non-power-of-two port count never selects a port that
    // does not exist.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        w_cand   = '0;
        for (int k = 0; k < int'(NUM_IN); k++) begin
            w_cand = {1'b0, r_ptr} + (IDX_W+1)'(k);
            if (w_cand >= (IDX_W+1)'(NUM_IN)) begin
                w_cand = w_cand - (IDX_W+1)'(NUM_IN);
            end
            if (!w_found && bus.in_valid_i[w_cand[IDX_W-1:0]]) begin
                w_found  = 1'b1;
                w_winner = w_cand[IDX_W-1:0];
            end
        end
    end

    // Pointer advances to the port after the winner, wrapping at the last port.
    assign w_nextPtr = (w_winner == IDX_W'(NUM_IN - 1)) ? '0 : w_winner + IDX_W'(1);

    // Only the winning port sees ready, and only when its word is actually
    // captured; held low during reset so nothing upstream thinks it handed off.
    always_comb begin
        w_grant = '0;
        if (w_ld && w_found && !rst_i) begin
            w_grant[w_winner] = 1'b1;
        end
    end

    // Output stage: flush empties it and rewinds the pointer, a load either
    // captures the winner or empties it when nobody is valid, and a stall
    // keeps everything so the core sees a stable word.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            r_valid <= 1'b0;
            r_data  <= '0;
            r_idx   <= '0;
            r_ptr   <= '0;
        end else if (flush_i) begin
            r_valid <= 1'b0;
            r_ptr   <= '0;
        end else if (w_ld) begin
            if (w_found) begin
                r_valid <= 1'b1;
                r_data  <= bus.in_data_i[w_winner];
                r_idx   <= w_winner;
                r_ptr   <= w_nextPtr;
            end else begin
                r_valid <= 1'b0;
            end
        end
    end

    assign bus.in_ready_o  = w_grant;
    assign bus.out_valid_o = r_valid;
    assign bus.out_data_o  = r_data;
    assign bus.out_idx_o   = r_idx;
    assign bus.busy_o      = r_valid || (|bus.in_valid_i);

endmodule

// File: tb/tb_fpnew_opgrp_out_arb.sv
// ---------------------------------------------------------------------------
// TbFpnewOpgrpOutArb
// Self-checking bench for the operation-group output arbiter. A table of
// per-cycle vectors gives inputs plus the expected ready pattern and output
// valid; captured words go into a scoreboard queue and are compared when the
// core side takes them.
// ---------------------------------------------------------------------------
module tb_fpnew_opgrp_out_arb;

    localparam int unsigned NUM_IN = 5;
    localparam int unsigned DATA_W = 70;
    localparam int unsigned IDX_W  = 3;

    typedef struct {
        logic [NUM_IN-1:0] inValid;
        logic              outReady;
        logic              flush;
        logic [NUM_IN-1:0] expInReady;
        logic              expOutValid;
    } vec_t;

    typedef struct {
        logic [DATA_W-1:0] data;
        logic [IDX_W-1:0]  idx;
    } sb_t;

    logic clock;
    logic reset;
    logic flush;

    fpnew_opgrp_out_arb_if #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) bus ();

    fpnew_opgrp_out_arb #(.NUM_IN(NUM_IN), .DATA_W(DATA_W)) dut (
        .clk_i   (clock),
        .rst_i   (reset),
        .flush_i (flush),
        .bus     (bus.slave)
    );

    int testsRun;
    int testsFailed;
    logic expValidQ;
    vec_t vecs[$];
    sb_t  sb[$];
    logic [NUM_IN-1:0][DATA_W-1:0] inData;

    // Free-running clock, period 10.
    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic checkOutput(input string name, input logic [127:0] actual,
                               input logic [127:0] expected);
        testsRun++;
        if (actual !== expected) begin
            testsFailed++;
            $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, actual, expected);
        end
    endtask

    task automatic addVec(input logic [NUM_IN-1:0] v, input logic r, input logic f,
                          input logic [NUM_IN-1:0] er, input logic ev);
        vec_t t;
        t.inValid = v; t.outReady = r; t.flush = f; t.expInReady = er; t.expOutValid = ev;
        vecs.push_back(t);
    endtask

    // One cycle: drive on the falling edge, check ready/busy and consume the
    // registered word before the rising edge, then check valid after it.
    task automatic applyStimulus(input vec_t v);
        sb_t exp;
        sb_t got;
        @(negedge clock);
        bus.in_valid_i  = v.inValid;
        bus.out_ready_i = v.outReady;
        bus.in_data_i   = inData;
        flush           = v.flush;
        #1;
        checkOutput("inReady", 128'(bus.in_ready_o), 128'(v.expInReady));
        checkOutput("busy", 128'(bus.busy_o), 128'(expValidQ | (|v.inValid)));
        if (bus.out_valid_o && v.outReady) begin
            if (sb.size() == 0) begin
                checkOutput("sbUnderflow", 128'(1), 128'(0));
            end else begin
                exp = sb.pop_front();
                got.data = bus.out_data_o;
                got.idx  = bus.out_idx_o;
                checkOutput("outData", 128'(got.data), 128'(exp.data));
                checkOutput("outIdx", 128'(got.idx), 128'(exp.idx));
            end
        end
        if (v.flush) sb.delete();
        for (int p = 0; p < int'(NUM_IN); p++) begin
            if (v.expInReady[p]) begin
                exp.data = inData[p];
                exp.idx  = IDX_W'(p);
                sb.push_back(exp);
            end
        end
        @(posedge clock);
        #1;
        checkOutput("outValid", 128'(bus.out_valid_o), 128'(v.expOutValid));
        expValidQ = v.expOutValid;
    endtask

    task automatic fillData(input int tag);
        for (int p = 0; p < int'(NUM_IN); p++) begin
            inData[p] = DATA_W'({32'(tag) * 32'h9E37_79B9, 8'(p), 8'hA5, 8'(tag)});
        end
    endtask

    // Stimulus: reset checks, a hand-written first transfer, the vector
    // table, then an asynchronous reset in the middle of a stall.
    initial begin
        vec_t v;
        testsRun    = 0;
        testsFailed = 0;
        expValidQ   = 1'b0;
        reset       = 1'b1;
        flush       = 1'b0;
        bus.in_valid_i  = '1;
        bus.out_ready_i = 1'b1;
        bus.in_data_i   = '0;
        inData          = '0;

        repeat (2) @(negedge clock);
        #1;
        checkOutput("rstOutValid", 128'(bus.out_valid_o), 128'(0));
        checkOutput("rstInReady", 128'(bus.in_ready_o), 128'(0));
        checkOutput("rstOutData", 128'(bus.out_data_o), 128'(0));
        checkOutput("rstOutIdx", 128'(bus.out_idx_o), 128'(0));
        bus.in_valid_i = '0;
        reset = 1'b0;

        // First transfer after reset: only port 2 valid with 0x2A.
        inData    = '0;
        inData[2] = DATA_W'(8'h2A);
        v.inValid = 5'b00100; v.outReady = 1'b1; v.flush = 1'b0;
        v.expInReady = 5'b00100; v.expOutValid = 1'b1;
        applyStimulus(v);
        checkOutput("firstData", 128'(bus.out_data_o), 128'(8'h2A));
        checkOutput("firstIdx", 128'(bus.out_idx_o), 128'(2));
        checkOutput("firstBusy", 128'(bus.busy_o), 128'(1));

        // Drain, then flush with nothing buffered to rewind the pointer to 0.
        addVec(5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0);
        addVec(5'b00000, 1'b1, 1'b1, 5'b00000, 1'b0);
        // All ports valid: grants rotate 0..4 then wrap to 0, no bubbles.
        addVec(5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1);
        addVec(5'b11111, 1'b1, 1'b0, 5'b00010, 1'b1);
        addVec(5'b11111, 1'b1, 1'b0, 5'b00100, 1'b1);
        addVec(5'b11111, 1'b1, 1'b0, 5'b01000, 1'b1);
        addVec(5'b11111, 1'b1, 1'b0, 5'b10000, 1'b1);
        addVec(5'b11111, 1'b1, 1'b0, 5'b00001, 1'b1);
        // Load port 1 (pointer now 2), stall three cycles with ports 0 and 3
        // valid, then release: port 3 wins.
        addVec(5'b00010, 1'b1, 1'b0, 5'b00010, 1'b1);
        addVec(5'b01001, 1'b0, 1'b0, 5'b00000, 1'b1);
        addVec(5'b01001, 1'b0, 1'b0, 5'b00000, 1'b1);
        addVec(5'b01001, 1'b0, 1'b0, 5'b00000, 1'b1);
        addVec(5'b01001, 1'b1, 1'b0, 5'b01000, 1'b1);
        // Pointer at 4, only port 0 valid: wrap to 0, pointer becomes 1.
        addVec(5'b00001, 1'b1, 1'b0, 5'b00001, 1'b1);
        addVec(5'b00011, 1'b1, 1'b0, 5'b00010, 1'b1);
        // Flush while stalled with a buffered word: ready held low, word dropped.
        addVec(5'b00100, 1'b0, 1'b1, 5'b00000, 1'b0);
        // Pointer back at 0: port 0 beats port 3.
        addVec(5'b01001, 1'b1, 1'b0, 5'b00001, 1'b1);
        // Load with nobody valid empties the register but keeps the pointer.
        addVec(5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0);
        addVec(5'b00011, 1'b1, 1'b0, 5'b00010, 1'b1);
        addVec(5'b00000, 1'b1, 1'b0, 5'b00000, 1'b0);
        // Fill the register (pointer 2 -> 3) ahead of the async reset.
        addVec(5'b00100, 1'b0, 1'b0, 5'b00100, 1'b1);

        for (int i = 0; i < vecs.size(); i++) begin
            fillData(i + 1);
            applyStimulus(vecs[i]);
        end

        // Asynchronous reset pulse between edges while stalled with valid data.
        @(negedge clock);
        bus.in_valid_i  = 5'b00000;
        bus.out_ready_i = 1'b0;
        #1;
        reset = 1'b1;
        #1;
        checkOutput("asyncRstValid", 128'(bus.out_valid_o), 128'(0));
        checkOutput("asyncRstReady", 128'(bus.in_ready_o), 128'(0));
        #1;
        reset = 1'b0;
        sb.delete();
        expValidQ = 1'b0;

        // After release the scan restarts at port 0, ahead of port 2.
        fillData(100);
        v.inValid = 5'b00101; v.outReady = 1'b1; v.flush = 1'b0;
        v.expInReady = 5'b00001; v.expOutValid = 1'b1;
        applyStimulus(v);
        v.inValid = 5'b00000; v.expInReady = 5'b00000; v.expOutValid = 1'b0;
        applyStimulus(v);
        checkOutput("sbEmpty", 128'(sb.size()), 128'(0));

        $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
        $finish;
    end

endmodule

// File: doc/fpnew_opgrp_out_arb.md
FPNEW_OPGRP_OUT_ARB -- requirements
Module: fpnew_opgrp_out_arb

Interface
REQ-001 The block SHALL have parameter NUM_IN, default 5, giving the number of operation-group result ports arbitrated.
REQ-002 The block SHALL have parameter DATA_W, default 70, giving the width of the packed result, status and tag word per port.
REQ-003 The block SHALL have parameter IDX_W, default $clog2(NUM_IN), giving the width of the winner index.
REQ-004 clk_i  input  1  sole clock; all state updates on rising edge.
REQ-005 rst_i  input  1  reset, asynchronous and active-high.
REQ-006 flush_i  input  1  synchronous flush; discards buffered result and restarts arbitration.
REQ-007 in_valid_i  input  NUM_IN  per-port result-valid from the operation groups.
REQ-008 in_ready_o  output  NUM_IN  per-port accept; at most one bit set per cycle.
REQ-009 in_data_i  input  NUM_IN x DATA_W  per-port packed result word.
REQ-010 out_valid_o  output  1  registered result valid toward the core.
REQ-011 out_ready_i  input  1  core accepts the result.
REQ-012 out_data_o  output  DATA_W  registered winning data word.
REQ-013 out_idx_o  output  IDX_W  port index that produced out_data_o.
REQ-014 busy_o  output  1  result pending anywhere in the block or at its inputs.

Function
REQ-015 The block SHALL hold one output register: valid_q, data_q, idx_q, driving out_valid_o, out_data_o and out_idx_o directly.
REQ-016 Load enable SHALL be ld = !flush_i & (!valid_q | out_ready_i).
REQ-017 The winner SHALL be the first port with in_valid_i set, scanning from rr pointer ptr_q upward with wrap from NUM_IN-1 to 0.
REQ-018 in_ready_o[winner] SHALL be 1 only when ld=1 and a winner exists; all other in_ready_o bits SHALL be 0.
REQ-019 On ld=1 with a winner: valid_q<=1, data_q<=in_data_i[winner], idx_q<=winner, ptr_q<=(winner+1) mod NUM_IN.
REQ-020 On ld=1 with no in_valid_i set: valid_q<=0; data_q, idx_q and ptr_q SHALL hold.
REQ-021 On ld=0 with flush_i=0, that is stall: valid_q, data_q, idx_q and ptr_q SHALL hold, and out_data_o SHALL stay stable while out_valid_o=1.
REQ-022 Latency SHALL be exactly 1 cycle from accepted input to out_valid_o; throughput SHALL be 1 result per cycle when out_ready_i=1.
REQ-023 A back-to-back case, with valid_q=1, out_ready_i=1 and a new winner in the same cycle, SHALL hand off the old result and load the new one with no bubble.
REQ-024 No input SHALL be starved: a continuously valid port SHALL be granted within NUM_IN accepted transfers.
REQ-025 flush_i=1 SHALL force in_ready_o=0, and SHALL set valid_q<=0 and ptr_q<=0 at the next edge; it SHALL take priority over ld and out_ready_i.
REQ-026 busy_o SHALL equal valid_q | (|in_valid_i), combinationally.
REQ-027 The ptr_q width SHALL be IDX_W, and wrap SHALL be explicit so that non-power-of-two NUM_IN never selects an index >= NUM_IN.
REQ-028 in_ready_o may depend combinationally on in_valid_i and out_ready_i; no output SHALL depend combinationally on in_data_i.

Reset
REQ-029 While rst_i=1, asynchronously: valid_q=0, data_q=0, idx_q=0, ptr_q=0; out_valid_o=0 and in_ready_o=0.
REQ-030 Reset asserted mid-stall SHALL drop the buffered result without handshake; the first grant after release SHALL start scanning from port 0.

Verification
REQ-031 Reset release, in_valid_i=5'b00100, data[2]=0x2A, out_ready_i=1 -> in_ready_o=5'b00100; next cycle out_valid_o=1, out_data_o=0x2A, out_idx_o=2, busy_o=1.
REQ-032 All 5 ports valid continuously, out_ready_i=1 -> out_idx_o sequence 0,1,2,3,4,0 on consecutive cycles, with no bubbles.
REQ-033 valid_q=1 (idx 1), out_ready_i=0 for 3 cycles, ports 0 and 3 valid -> in_ready_o=0 and out_data_o/out_idx_o stable for 3 cycles; on out_ready_i=1 the next winner is 3 (ptr=2).
REQ-034 ptr_q=4, only port 0 valid -> winner 0 (wrap), ptr_q becomes 1.
REQ-035 flush_i=1 with valid_q=1 and out_ready_i=0 -> next cycle out_valid_o=0, ptr_q=0, and in_ready_o=0 during the flush cycle.
REQ-036 rst_i pulsed asynchronously between edges while valid_q=1 -> out_valid_o falls immediately; after release with ports 2 and 0 valid, the winner is 0.
